// File: rtl/riscv_pkg.sv
// Shared RISC-V base-ISA constants: major opcodes, instruction format codes
// and the opcode-to-format mapping used by the decode stage.
package riscv_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_NONE = 3'd7
    } fmt_e;

    function automatic fmt_e opcode_to_fmt(input logic [6:0] opc);
        fmt_e fmt;
        case (opc)
            OPC_OP:                                  fmt = FMT_R;
            OPC_OP_IMM, OPC_LOAD, OPC_JALR:          fmt = FMT_I;
            OPC_SYSTEM, OPC_FENCE:                   fmt = FMT_I;
            OPC_STORE:                               fmt = FMT_S;
            OPC_BRANCH:                              fmt = FMT_B;
            OPC_LUI, OPC_AUIPC:                      fmt = FMT_U;
            OPC_JAL:                                 fmt = FMT_J;
            default:                                 fmt = FMT_NONE;
        endcase
        return fmt;
    endfunction

endpackage

// File: rtl/decode_imm_gen.sv
// Combinational immediate generator: picks the immediate layout by format
// and sign-extends it from instr[31] to XLEN bits.
module decode_imm_gen
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  fmt_e            fmt,
    output logic [XLEN-1:0] imm
);

    logic [31:0] imm32;

    always_comb begin
        imm32 = '0;
        case (fmt)
            FMT_I: imm32 = {{20{instr[31]}}, instr[31:20]};
            FMT_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                            instr[11:8], 1'b0};
            FMT_U: imm32 = {instr[31:12], 12'h000};
            FMT_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                            instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    // Every 32-bit form already carries its sign in bit 31.
    if (XLEN > 32) begin : g_wide
        assign imm = {{(XLEN-32){imm32[31]}}, imm32};
    end else begin : g_narrow
        assign imm = imm32;
    end

endmodule

// File: rtl/decode_stage.sv
// Single registered decode stage with valid/ready handshake: slices fields,
// classifies format, builds the immediate and flags unsupported encodings.
module decode_stage
    import riscv_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter bit EN_SYSTEM = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_ni,

    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,

    input  logic            flush_i,

    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] pc_o,
    output logic [6:0]      opcode_o,
    output logic [2:0]      funct3_o,
    output logic [6:0]      funct7_o,
    output logic [4:0]      rs1_o,
    output logic [4:0]      rs2_o,
    output logic [4:0]      rd_o,
    output logic [XLEN-1:0] imm_o,
    output logic [2:0]      fmt_o,
    output logic            illegal_o
);

    logic            out_valid_q;
    logic [31:0]     instr_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] imm_q;
    fmt_e            fmt_q;
    logic            illegal_q;

    logic [6:0]      opc_d;
    logic [6:0]      funct7_d;
    fmt_e            fmt_d;
    logic            illegal_d;
    logic [XLEN-1:0] imm_d;
    logic            capture;

    assign in_ready_o = !out_valid_q || out_ready_i;
    assign capture    = in_valid_i && in_ready_o && !flush_i;

    assign opc_d    = instr_i[6:0];
    assign funct7_d = instr_i[31:25];
    assign fmt_d    = opcode_to_fmt(opc_d);

    always_comb begin
        illegal_d = 1'b0;
        if (instr_i[1:0] != 2'b11)
            illegal_d = 1'b1;
        if (fmt_d == FMT_NONE)
            illegal_d = 1'b1;
        if (opc_d == OPC_OP && funct7_d != 7'h00 && funct7_d != 7'h20)
            illegal_d = 1'b1;
        if (!EN_SYSTEM && (opc_d == OPC_SYSTEM || opc_d == OPC_FENCE))
            illegal_d = 1'b1;
    end

    decode_imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr (instr_i),
        .fmt   (fmt_d),
        .imm   (imm_d)
    );

    // Flush only kills the valid bit; payload registers keep their last value.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            instr_q     <= '0;
            pc_q        <= '0;
            imm_q       <= '0;
            fmt_q       <= FMT_NONE;
            illegal_q   <= 1'b0;
        end else if (flush_i) begin
            out_valid_q <= 1'b0;
        end else if (capture) begin
            out_valid_q <= 1'b1;
            instr_q     <= instr_i;
            pc_q        <= pc_i;
            imm_q       <= imm_d;
            fmt_q       <= fmt_d;
            illegal_q   <= illegal_d;
        end else if (out_ready_i) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid_o = out_valid_q;
    assign pc_o        = pc_q;
    assign opcode_o    = instr_q[6:0];
    assign rd_o        = instr_q[11:7];
    assign funct3_o    = instr_q[14:12];
    assign rs1_o       = instr_q[19:15];
    assign rs2_o       = instr_q[24:20];
    assign funct7_o    = instr_q[31:25];
    assign imm_o       = imm_q;
    assign fmt_o       = fmt_q;
    assign illegal_o   = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a 32-bit instance with SYSTEM enabled and
// a 64-bit instance with SYSTEM disabled share the same stimulus.
module tb_decode_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        flush;
    logic        out_ready;

    logic        in_ready;
    logic        out_valid;
    logic [31:0] pc_o;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        illegal;

    logic        in_ready64;
    logic        out_valid64;
    logic [63:0] pc64_o;
    logic [6:0]  opcode64;
    logic [2:0]  funct3_64;
    logic [6:0]  funct7_64;
    logic [4:0]  rs1_64, rs2_64, rd_64;
    logic [63:0] imm64;
    logic [2:0]  fmt64;
    logic        illegal64;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] delivered[$];

    decode_stage #(.XLEN(32), .EN_SYSTEM(1'b1)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .instr_i(instr), .pc_i(pc),
        .flush_i(flush),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .pc_o(pc_o),
        .opcode_o(opcode), .funct3_o(funct3), .funct7_o(funct7),
        .rs1_o(rs1), .rs2_o(rs2), .rd_o(rd),
        .imm_o(imm), .fmt_o(fmt), .illegal_o(illegal)
    );

    decode_stage #(.XLEN(64), .EN_SYSTEM(1'b0)) dut64 (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready64), .instr_i(instr),
        .pc_i({32'h0, pc}),
        .flush_i(flush),
        .out_valid_o(out_valid64), .out_ready_i(out_ready), .pc_o(pc64_o),
        .opcode_o(opcode64), .funct3_o(funct3_64), .funct7_o(funct7_64),
        .rs1_o(rs1_64), .rs2_o(rs2_64), .rd_o(rd_64),
        .imm_o(imm64), .fmt_o(fmt64), .illegal_o(illegal64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk)
        if (rst_n && out_valid && out_ready)
            delivered.push_back(pc_o);

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the capturing posedge.
    task automatic issue(input logic [31:0] w, input logic [31:0] p);
        in_valid = 1'b1;
        instr    = w;
        pc       = p;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic check_dec(input string tag, input logic [4:0] e_rd, input logic [4:0] e_rs1,
                             input logic [2:0] e_fmt, input logic [31:0] e_imm,
                             input logic e_ill);
        check_eq({tag, ".valid"},   out_valid, 1'b1);
        check_eq({tag, ".rd"},      rd,        e_rd);
        check_eq({tag, ".rs1"},     rs1,       e_rs1);
        check_eq({tag, ".fmt"},     fmt,       e_fmt);
        check_eq({tag, ".imm"},     imm,       e_imm);
        check_eq({tag, ".illegal"}, illegal,   e_ill);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; instr = '0; pc = '0;
        flush = 1'b0; out_ready = 1'b1;

        #12;
        check_eq("rst.valid",   out_valid, 1'b0);
        check_eq("rst.fmt",     fmt,       3'd7);
        check_eq("rst.pc",      pc_o,      32'h0);
        check_eq("rst.imm",     imm,       32'h0);
        check_eq("rst.illegal", illegal,   1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst.in_ready", in_ready, 1'b1);

        // Back-to-back decodes with downstream always ready
        issue(32'hFFF10093, 32'h100);
        check_dec("addi", 5'd1, 5'd2, 3'd1, 32'hFFFFFFFF, 1'b0);
        check_eq("addi.pc",     pc_o,   32'h100);
        check_eq("addi.opcode", opcode, 7'h13);

        issue(32'h123452B7, 32'h104);
        check_dec("lui", 5'd5, 5'd8, 3'd4, 32'h12345000, 1'b0);

        issue(32'hFE000EE3, 32'h108);
        check_dec("beq", 5'd29, 5'd0, 3'd3, 32'hFFFFFFFC, 1'b0);
        check_eq("beq64.imm", imm64,  64'hFFFFFFFFFFFFFFFC);
        check_eq("beq64.pc",  pc64_o, 64'h108);

        issue(32'h008000EF, 32'h10C);
        check_dec("jal", 5'd1, 5'd0, 3'd5, 32'h00000008, 1'b0);

        issue(32'h0020A423, 32'h110);
        check_dec("sw", 5'd8, 5'd1, 3'd2, 32'h00000008, 1'b0);
        check_eq("sw.rs2",    rs2,    5'd2);
        check_eq("sw.funct3", funct3, 3'd2);

        issue(32'h002081B3, 32'h114);
        check_dec("add", 5'd3, 5'd1, 3'd0, 32'h0, 1'b0);
        check_eq("add.rs2", rs2, 5'd2);

        issue(32'h402081B3, 32'h118);
        check_dec("sub", 5'd3, 5'd1, 3'd0, 32'h0, 1'b0);
        check_eq("sub.funct7", funct7, 7'h20);

        issue(32'h022081B3, 32'h11C);
        check_dec("mul", 5'd3, 5'd1, 3'd0, 32'h0, 1'b1);

        issue(32'h00000073, 32'h120);
        check_dec("ecall", 5'd0, 5'd0, 3'd1, 32'h0, 1'b0);
        check_eq("ecall64.illegal", illegal64, 1'b1);

        @(negedge clk);
        check_eq("drain.valid", out_valid, 1'b0);

        // Backpressure with a second instruction waiting
        delivered.delete();
        out_ready = 1'b0;
        issue(32'hFFF10093, 32'h200);
        in_valid = 1'b1; instr = 32'h123452B7; pc = 32'h204;
        check_eq("bp.valid",    out_valid, 1'b1);
        check_eq("bp.in_ready", in_ready,  1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("bp.hold_pc",    pc_o,      32'h200);
            check_eq("bp.hold_imm",   imm,       32'hFFFFFFFF);
            check_eq("bp.hold_valid", out_valid, 1'b1);
            check_eq("bp.in_ready",   in_ready,  1'b0);
        end
        out_ready = 1'b1;
        #1;
        check_eq("bp.release_ready", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("bp.second_valid", out_valid, 1'b1);
        check_eq("bp.second_pc",    pc_o,      32'h204);
        check_eq("bp.second_rd",    rd,        5'd5);
        @(negedge clk);
        check_eq("bp.drained",  out_valid,        1'b0);
        check_eq("bp.count",    delivered.size(), 2);
        check_eq("bp.first",    delivered[0],     32'h200);
        check_eq("bp.second",   delivered[1],     32'h204);

        // Flush coinciding with an incoming instruction
        in_valid = 1'b1; instr = 32'h008000EF; pc = 32'h300; flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        check_eq("flush.valid", out_valid, 1'b0);
        check_eq("flush.pc",    pc_o,      32'h204);
        @(negedge clk);
        check_eq("flush.valid2", out_valid,        1'b0);
        check_eq("flush.count",  delivered.size(), 2);

        // Flush while holding under backpressure
        out_ready = 1'b0;
        issue(32'h0020A423, 32'h500);
        check_eq("hflush.valid_before", out_valid, 1'b1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check_eq("hflush.valid", out_valid, 1'b0);
        check_eq("hflush.pc",    pc_o,      32'h500);

        // Illegal word held, then asynchronous reset
        issue(32'h00000000, 32'h600);
        check_eq("ill.valid",   out_valid, 1'b1);
        check_eq("ill.illegal", illegal,   1'b1);
        check_eq("ill.fmt",     fmt,       3'd7);
        check_eq("ill.imm",     imm,       32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst.valid", out_valid, 1'b0);
        check_eq("arst.pc",    pc_o,      32'h0);
        check_eq("arst.fmt",   fmt,       3'd7);
        check_eq("arst.ill",   illegal,   1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("arst.in_ready", in_ready, 1'b1);
        @(negedge clk);
        check_eq("arst.valid_after", out_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, immediate and PC width; legal values 32 or 64.
REQ-002 SHALL have parameter EN_SYSTEM, default 1; when 1, SYSTEM/FENCE opcodes decode as legal, otherwise as illegal.
REQ-003 SHALL have one clock and asynchronous active-low reset:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
REQ-004 SHALL have these upstream ports:
- in_valid_i  in  1  instruction word valid
- in_ready_o  out  1  stage can accept
- instr_i  in  32  raw instruction
- pc_i  in  XLEN  instruction PC
REQ-005 SHALL have flush_i  in  1, which discards the held and incoming instruction.
REQ-006 SHALL have these downstream ports:
- out_valid_o  out  1
- out_ready_i  in  1
- pc_o  out  XLEN
- opcode_o  out  7
- funct3_o  out  3
- funct7_o  out  7
- rs1_o  out  5
- rs2_o  out  5
- rd_o  out  5
REQ-007 SHALL have imm_o  out  XLEN, the immediate selected by instruction format and sign-extended to XLEN.
REQ-008 SHALL have fmt_o  out  3, the format code: R=0, I=1, S=2, B=3, U=4, J=5, NONE=7.
REQ-009 SHALL have illegal_o  out  1, flagging an unsupported encoding.

Function
REQ-010 SHALL be a single registered stage: instruction accepted in cycle N appears on outputs from cycle N+1.
REQ-011 SHALL drive in_ready_o = !out_valid_o || out_ready_i, combinationally.
REQ-012 SHALL capture an instruction on in_valid_i && in_ready_o && !flush_i, and set out_valid_o next cycle.
REQ-013 SHALL hold all outputs stable while out_valid_o && !out_ready_i.
REQ-014 SHALL clear out_valid_o when downstream accepts and no new capture occurs.
REQ-015 SHALL give flush_i priority over capture and hold; out_valid_o is 0 in the next cycle and data outputs keep their values.
REQ-016 SHALL slice fields from the instruction as follows:
- opcode [6:0], rd [11:7], funct3 [14:12]
- rs1 [19:15], rs2 [24:20], funct7 [31:25]
REQ-017 SHALL form immediates as follows, each sign-extended from instr[31] to XLEN:
- I = instr[31:20]
- S = {instr[31:25], instr[11:7]}
- B = {instr[31], instr[7], instr[30:25], instr[11:8], 0}
- U = {instr[31:12], 12'h000}
- J = {instr[31], instr[19:12], instr[20], instr[30:21], 0}
REQ-018 SHALL map opcode to format as follows:
- OP = R
- OP-IMM, LOAD, JALR = I
- STORE = S
- BRANCH = B
- LUI, AUIPC = U
- JAL = J
- SYSTEM, FENCE = I
- any other opcode = NONE
REQ-019 SHALL drive imm_o to 0 when fmt is R or NONE.
REQ-020 SHALL assert illegal_o in any of these cases:
- instr[1:0] != 2'b11
- fmt is NONE
- OP with funct7 not 0x00/0x20
- SYSTEM/FENCE when EN_SYSTEM=0
REQ-021 SHALL still present an illegal instruction with out_valid_o=1; the stage never drops it.
REQ-022 SHALL pass pc_i to pc_o unchanged, registered alongside the instruction.

Reset
REQ-023 SHALL, while rst_ni=0, force out_valid_o=0, all data outputs to 0, and fmt_o=7, asynchronously.
REQ-024 SHALL discard an instruction held at reset assertion; after release, in_ready_o=1 in the first cycle.

Structure
REQ-025 SHALL take opcode constants, the format enum and format codes from shared package riscv_pkg.
REQ-026 SHALL implement immediate formation in combinational sub-module decode_imm_gen (instr, fmt -> imm, parameter XLEN).

Verification
REQ-027 SHALL cover I-type decode: 0xFFF10093 (addi x1,x2,-1) -> next cycle out_valid_o=1, fmt=1, rd=1, rs1=2, imm=0xFFFFFFFF.
REQ-028 SHALL cover U and B decode: 0x123452B7 -> imm=0x12345000, rd=5, fmt=4; 0xFE000EE3 (beq -4) -> imm=0xFFFFFFFC, fmt=3.
REQ-029 SHALL cover J decode: 0x008000EF (jal x1,+8) -> imm=0x00000008, rd=1, fmt=5; XLEN=64 run with 0xFE000EE3 -> imm=0xFFFFFFFFFFFFFFFC.
REQ-030 SHALL cover backpressure: out_ready_i=0 for 3 cycles with a second instruction pending -> outputs unchanged, in_ready_o=0; on release both instructions are delivered in order, none lost.
REQ-031 SHALL cover flush: flush_i coinciding with in_valid_i -> next cycle out_valid_o=0; the flushed instruction never appears.
REQ-032 SHALL cover illegal and reset: 0x00000000 -> illegal_o=1, fmt=7, out_valid_o=1; rst_ni pulsed low while holding -> out_valid_o=0 immediately.
